// File: rtl/key_expand.sv
// Iterative AES-128 key expansion: derives ten round keys one per clock into
// an 11-entry key file, then serves them by index with a registered read port.
module key_expand (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         ready_o,
    input  logic [3:0]   rd_idx_i,
    output logic [127:0] rd_key_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int unsigned LAST_IDX = 10;

    // Forward AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   state;
    logic [3:0]   step_cnt;
    logic [127:0] key_mem [0:LAST_IDX];
    logic [127:0] rd_key;

    logic [3:0]        prev_idx;
    logic [127:0]      prev_key;
    logic [127:0]      next_key;
    logic [31:0]       t_word;
    logic [3:0][31:0]  w;
    logic [3:0][31:0]  wn;

    // Word j of a row-major key is column j: byte j taken from every row.
    always_comb begin
        prev_idx = (step_cnt == 4'd0) ? 4'd0 : step_cnt - 4'd1;
        prev_key = (prev_idx <= 4'(LAST_IDX)) ? key_mem[prev_idx] : '0;
        w        = '0;
        wn       = '0;
        next_key = '0;
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < 4; r++) begin
                w[j][31 - 8*r -: 8] = prev_key[127 - 32*r - 8*j -: 8];
            end
        end
        t_word = sub_word({w[3][23:0], w[3][31:24]}) ^ {rcon(step_cnt), 24'h000000};
        wn[0]  = w[0] ^ t_word;
        for (int j = 1; j < 4; j++) begin
            wn[j] = w[j] ^ wn[j-1];
        end
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < 4; r++) begin
                next_key[127 - 32*r - 8*j -: 8] = wn[j][31 - 8*r -: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            step_cnt <= 4'd0;
            rd_key   <= '0;
            // NOTE: the key file is cleared on reset so an aborted expansion never leaves readable key material behind.
            for (int i = 0; i <= LAST_IDX; i++) begin
                key_mem[i] <= '0;
            end
        end else begin
            rd_key <= (rd_idx_i <= 4'(LAST_IDX)) ? key_mem[rd_idx_i] : '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        key_mem[0] <= key_i;
                        step_cnt   <= 4'd1;
                        state      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    key_mem[step_cnt] <= next_key;
                    step_cnt          <= step_cnt + 4'd1;
                    if (step_cnt == 4'(LAST_IDX)) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o   = (state == ST_EXPAND);
    assign ready_o  = (state == ST_DONE);
    assign rd_key_o = rd_key;

endmodule

// File: doc/key_expand.md
# key_expand

Iterative AES-128 key-expansion unit that sits directly upstream of the `round` datapath and supplies its `key_i` operand. On a start pulse it latches the cipher key and derives the ten round keys, one per clock. All eleven keys are stored in an internal key file. The round controller then reads them by index: ascending order for encryption, descending order for decryption. Keys are held in the same row-major 128-bit state layout that `round` consumes, so `add_round_key` can XOR them directly.

## Interface
- Parameters: none. AES-128 only; fixed 11 keys and 10 expansion steps.
- `clk_i`  in  1  Clock; all state updates on the rising edge.
- `rst_i`  in  1  Reset; synchronous, active-high.
- `start_i`  in  1  Start pulse; sampled only when `busy_o`=0.
- `key_i`  in  128  Cipher key, row-major. `[127:96]` is row 0 = bytes k0,k4,k8,k12; `[31:0]` is row 3 = k3,k7,k11,k15.
- `busy_o`  out  1  Expansion in progress.
- `ready_o`  out  1  All 11 keys are valid.
- `rd_idx_i`  in  4  Round-key index, 0..10.
- `rd_key_o`  out  128  Registered read data, row-major layout.

## Operation
- **States.** IDLE (busy=0, ready=0), EXPAND (busy=1, ready=0), DONE (busy=0, ready=1).
- **Start.**
  - IDLE or DONE with `start_i`=1: entry 0 <= `key_i`, step counter <= 1, go to EXPAND. `ready_o` drops.
  - `start_i` during EXPAND is ignored. The in-flight expansion continues unchanged.
- **EXPAND step n (1..10).**
  - Let word w[j] be column j of entry n-1, i.e. byte j of each row.
  - t = SubWord(RotWord(w[3])) ^ Rcon[n]. Use forward S-box only, via the existing `sub_word` with `enc_or_dec_i`=1.
  - RotWord maps bytes {a,b,c,d} to {b,c,d,a}, where a is the row-0 byte.
  - Rcon[n] sits in the row-0 byte; other rows are 00. Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - Outputs: w'[0]=w[0]^t, w'[1]=w[1]^w'[0], w'[2]=w[2]^w'[1], w'[3]=w[3]^w'[2].
  - Entry n <= {w'} reassembled in row-major layout. Counter increments.
  - After step 10 is written, go to DONE.
- **Read.** `rd_key_o` <= entry[`rd_idx_i`] every cycle, regardless of state.
  - Index 11..15: `rd_key_o` <= 0.
  - Entries not yet written in the current expansion return stale or zero content. Consumers must wait for `ready_o`.
- **Key file.** 11 × 128-bit registers. Entries are written only by the start load and by expansion steps.

## Timing
- **Reset values.** `busy_o`=0, `ready_o`=0, `rd_key_o`=0. Counter=0, all key entries=0, state IDLE.
- **Reset mid-EXPAND.** Return to IDLE with all of the above cleared on the next edge. No partial `ready_o`.
- **Start sequence.**
  - `start_i` is sampled at edge T0. `busy_o`=1 from T0.
  - Entries 1..10 are written at edges T1..T10.
  - At T10 `busy_o` goes 0 and `ready_o` goes 1.
  - Total latency: 10 cycles from the start edge to `ready_o`.
- **Read latency.** 1 cycle: `rd_idx_i` presented before edge T gives `rd_key_o` valid after T.
- **Simultaneous start and read in DONE.** The read returns the old entry for that cycle. `ready_o` falls at the same edge.
- **`rst_i` and `start_i` both high.** Reset wins.
- **Exit from DONE.** DONE persists until the next `start_i` or `rst_i`.

## Test plan
- **FIPS-197 key.** `key_i`=2b28ab09_7eaef7cf_15d2154f_16a6883c, pulse start. Required:
  - `ready_o` rises exactly 10 cycles after the start edge.
  - idx 0 returns the key unchanged.
  - idx 1 returns a088232a_fa54a36c_fe2c3976_17b13905.
  - idx 10 returns d0c9e1b6_14ee3f63_f9250c0c_a889c8a6.
- **All-zero key.** idx 1 = 62626262_63636363_63636363_63636363. idx 0 = 0.
- **Start during EXPAND.** Pulse start with a different key at cycle 4 after the first start. Required: ignored, and the results match the first key.
- **Reset at cycle 5 of EXPAND.** Required: busy=0, ready=0 next cycle; `rd_key_o` reads 0 for every idx.
- **Out-of-range and ordering.** Read idx 10 down to 0 back-to-back, then idx 11, 15. Required: each key appears one cycle after its index; idx 11 and 15 return 0.
- **Restart from DONE.** Apply a new key. Required: ready falls at the start edge, rises again 10 cycles later, and the new idx 10 matches the reference model.
